full_adder_pipe: RTL and testbench
==================================

Name: full_adder_pipe

Overview:
Parameterizable ripple-carry full-adder block used as the bit-level adder primitive of the scalar ALU adder.
- Adds two WIDTH-bit operands plus a 1-bit carry-in, producing a WIDTH-bit sum and a carry-out.
- The default configuration (WIDTH=1) is the classic 1-bit full adder.
- Optional output register stage, controlled by parameter, allows use in pipelined datapaths.

Parameters:
WIDTH, 1, operand/sum width in bits; legal range >= 1.
REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = purely combinational outputs.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operands on A/B/C_in are valid this cycle.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
C_in  input  1  carry into bit 0.
R  output  WIDTH  sum result.
C_out  output  1  carry out of bit WIDTH-1.
out_valid  output  1  R/C_out hold a valid result.

Behaviour:
- Bit cell i: s_i = A[i] ^ B[i] ^ c_i; c_(i+1) = (A[i] & B[i]) | (c_i & (A[i] ^ B[i])); c_0 = C_in.
- Cells are chained by ripple carry.
- Combined result: {C_out, R} = A + B + C_in, evaluated at WIDTH+1 bits, with no truncation of the carry.
- Operands are unsigned. Signed overflow is not reported.
- REG_OUT=1:
  - On each rising clk with rst_n=0: R <= 0, C_out <= 0, out_valid <= 0. Reset takes priority over in_valid.
  - On each rising clk with rst_n=1 and in_valid=1: R and C_out capture the combinational sum/carry of the current inputs; out_valid <= 1.
  - On each rising clk with rst_n=1 and in_valid=0: R and C_out hold their previous values; out_valid <= 0.
  - Latency is exactly 1 cycle, throughput is 1 result per cycle, and there is no backpressure.
  - Reset asserted mid-stream clears the outputs at the next edge. Any operand presented in that cycle is lost.
- REG_OUT=0:
  - R and C_out are continuous functions of A, B and C_in. They change within the same delta/cycle.
  - out_valid = in_valid & rst_n, combinationally.
  - clk is unused; rst_n gates only out_valid.
- No X propagation masking: X on any input may produce X on the outputs.
- Boundary: all-ones operands with C_in=1 give R = all-ones and C_out = 1. All-zeros with C_in=0 gives R = 0 and C_out = 0.

Test Plan:
- WIDTH=1, REG_OUT=0, exhaustive truth table (A,B,C_in from 000 to 111), 1 time unit apart -> (R,C_out) = 00,10,10,01,10,01,01,11 respectively.
- WIDTH=1, REG_OUT=1, rst_n=0 for 2 cycles, then drive the same 8 vectors with in_valid=1 -> during reset R=0, C_out=0, out_valid=0; each result appears 1 cycle after its input, matching the truth table above.
- WIDTH=8, REG_OUT=1: A=8'hFF, B=8'h00, C_in=1 -> next cycle R=8'h00, C_out=1 (full carry ripple). Then A=8'h5A, B=8'hA5, C_in=0 -> R=8'hFF, C_out=0.
- WIDTH=8, REG_OUT=1: drive A=8'h80, B=8'h80, C_in=0 with in_valid=1, then in_valid=0 for 3 cycles with random A/B -> R=8'h00, C_out=1 held; out_valid high for 1 cycle, then low.
- Reset mid-operation, WIDTH=4, REG_OUT=1: stream A=4'h7, B=4'h9, C_in=0 with rst_n dropped on cycle 2 -> at the next edge R=0, C_out=0, out_valid=0; after rst_n returns high, the next valid input yields R=4'h0, C_out=1.
- Randomized, WIDTH=16, both REG_OUT values, 1000 vectors -> {C_out,R} == A+B+C_in (17-bit) at the correct latency.

Source files
------------

// File: rtl/full_adder_pipe_if.sv
// full_adder_pipe_if
//   Operand/result bundle for full_adder_pipe.
//   master : drives in_valid, A, B, C_in; receives R, C_out, out_valid
//   slave  : the adder side (receives operands, drives results)
interface full_adder_pipe_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic [WIDTH-1:0] R;
  logic             C_out;
  logic             out_valid;

  modport master (
    output in_valid, A, B, C_in,
    input  R, C_out, out_valid
  );

  modport slave (
    input  in_valid, A, B, C_in,
    output R, C_out, out_valid
  );
endinterface

// File: rtl/full_adder_pipe.sv
// full_adder_pipe
//   Ripple-carry adder of WIDTH full-adder cells: {C_out, R} = A + B + C_in.
//   REG_OUT=1 registers R/C_out/out_valid (1-cycle latency, results held
//   while in_valid is low); REG_OUT=0 is purely combinational.
// Ports:
//   clk   : rising-edge clock (unused when REG_OUT=0)
//   rst_n : synchronous active-low reset (gates out_valid when REG_OUT=0)
//   bus   : full_adder_pipe_if slave (in_valid, A, B, C_in -> R, C_out, out_valid)
module full_adder_pipe #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  full_adder_pipe_if.slave  bus
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  // Bit-cell chain; carry[i] is the carry into cell i, carry[WIDTH] is C_out.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = bus.C_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = bus.A[i] ^ bus.B[i] ^ carry[i];
      carry[i+1] = (bus.A[i] & bus.B[i]) | (carry[i] & (bus.A[i] ^ bus.B[i]));
    end
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    // Result registers hold when no operand arrives; valid is a one-cycle pulse.
    always_comb begin
      r_d = r_q;
      c_d = c_q;
      v_d = 1'b0;
      if (bus.in_valid) begin
        r_d = sum;
        c_d = carry[WIDTH];
        v_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else begin
        r_q <= r_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end

    assign bus.R         = r_q;
    assign bus.C_out     = c_q;
    assign bus.out_valid = v_q;
  end else begin : g_comb
    assign bus.R         = sum;
    assign bus.C_out     = carry[WIDTH];
    assign bus.out_valid = bus.in_valid & rst_n;
  end

endmodule

// File: tb/tb_full_adder_pipe.sv
// tb_full_adder_pipe
//   Self-checking bench for full_adder_pipe across several WIDTH/REG_OUT
//   configurations; expected values come from plain integer addition.
module tb_full_adder_pipe;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  full_adder_pipe_if #(.WIDTH(1))  if1c ();
  full_adder_pipe_if #(.WIDTH(1))  if1r ();
  full_adder_pipe_if #(.WIDTH(8))  if8r ();
  full_adder_pipe_if #(.WIDTH(4))  if4r ();
  full_adder_pipe_if #(.WIDTH(16)) if16r ();
  full_adder_pipe_if #(.WIDTH(16)) if16c ();

  full_adder_pipe #(.WIDTH(1),  .REG_OUT(1'b0)) u_w1c  (.clk(clk), .rst_n(rst_n), .bus(if1c));
  full_adder_pipe #(.WIDTH(1),  .REG_OUT(1'b1)) u_w1r  (.clk(clk), .rst_n(rst_n), .bus(if1r));
  full_adder_pipe #(.WIDTH(8),  .REG_OUT(1'b1)) u_w8r  (.clk(clk), .rst_n(rst_n), .bus(if8r));
  full_adder_pipe #(.WIDTH(4),  .REG_OUT(1'b1)) u_w4r  (.clk(clk), .rst_n(rst_n), .bus(if4r));
  full_adder_pipe #(.WIDTH(16), .REG_OUT(1'b1)) u_w16r (.clk(clk), .rst_n(rst_n), .bus(if16r));
  full_adder_pipe #(.WIDTH(16), .REG_OUT(1'b0)) u_w16c (.clk(clk), .rst_n(rst_n), .bus(if16c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  e2;
    logic [8:0]  e9;
    logic [4:0]  e5;
    logic [16:0] e17;
    logic [15:0] a16, b16;
    logic        c1, v1;
    logic [1:0]  hold_w1;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    {if1c.in_valid, if1c.A, if1c.B, if1c.C_in}     = '0;
    {if1r.in_valid, if1r.A, if1r.B, if1r.C_in}     = '0;
    {if8r.in_valid, if8r.A, if8r.B, if8r.C_in}     = '0;
    {if4r.in_valid, if4r.A, if4r.B, if4r.C_in}     = '0;
    {if16r.in_valid, if16r.A, if16r.B, if16r.C_in} = '0;
    {if16c.in_valid, if16c.A, if16c.B, if16c.C_in} = '0;

    // Reset for 2 cycles; operands offered during reset must not appear.
    if1r.in_valid = 1'b1;
    if1r.A = 1'b1; if1r.B = 1'b1; if1r.C_in = 1'b1;
    if1c.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_val("rst_w1r_R",   32'(if1r.R),         32'd0);
      check_val("rst_w1r_C",   32'(if1r.C_out),     32'd0);
      check_val("rst_w1r_ov",  32'(if1r.out_valid), 32'd0);
      check_val("rst_w8r_ov",  32'(if8r.out_valid), 32'd0);
      check_val("rst_w1c_ov",  32'(if1c.out_valid), 32'd0);
    end
    rst_n = 1'b1;

    // W1 combinational: exhaustive truth table.
    for (int v = 0; v < 8; v++) begin
      if1c.A = v[2]; if1c.B = v[1]; if1c.C_in = v[0];
      #1;
      e2 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      check_val("w1c_sum", 32'({if1c.C_out, if1c.R}), 32'(e2));
      check_val("w1c_ov",  32'(if1c.out_valid),        32'd1);
    end
    if1c.in_valid = 1'b0;
    #1;
    check_val("w1c_ov_low", 32'(if1c.out_valid), 32'd0);

    // W1 registered: back-to-back truth table, 1-cycle latency.
    for (int v = 0; v < 8; v++) begin
      if1r.A = v[2]; if1r.B = v[1]; if1r.C_in = v[0];
      tick();
      e2 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      check_val("w1r_sum", 32'({if1r.C_out, if1r.R}), 32'(e2));
      check_val("w1r_ov",  32'(if1r.out_valid),        32'd1);
    end
    hold_w1 = 2'b11;
    if1r.in_valid = 1'b0;
    if1r.A = 1'b0; if1r.B = 1'b0; if1r.C_in = 1'b0;
    tick();
    check_val("w1r_hold", 32'({if1r.C_out, if1r.R}), 32'(hold_w1));
    check_val("w1r_ov0",  32'(if1r.out_valid),        32'd0);

    // W8 full carry ripple, then no-carry pattern.
    if8r.in_valid = 1'b1;
    if8r.A = 8'hFF; if8r.B = 8'h00; if8r.C_in = 1'b1;
    tick();
    check_val("w8_ripple_R", 32'(if8r.R),     32'h00);
    check_val("w8_ripple_C", 32'(if8r.C_out), 32'd1);
    if8r.A = 8'h5A; if8r.B = 8'hA5; if8r.C_in = 1'b0;
    tick();
    check_val("w8_5aa5_R", 32'(if8r.R),     32'hFF);
    check_val("w8_5aa5_C", 32'(if8r.C_out), 32'd0);
    if8r.A = 8'hFF; if8r.B = 8'hFF; if8r.C_in = 1'b1;
    tick();
    e9 = 9'h0FF + 9'h0FF + 9'd1;
    check_val("w8_allones", 32'({if8r.C_out, if8r.R}), 32'(e9));

    // W8 hold while in_valid is low with changing operands.
    if8r.A = 8'h80; if8r.B = 8'h80; if8r.C_in = 1'b0;
    tick();
    check_val("w8_hold_R0",  32'(if8r.R),         32'h00);
    check_val("w8_hold_C0",  32'(if8r.C_out),     32'd1);
    check_val("w8_hold_ov0", 32'(if8r.out_valid), 32'd1);
    if8r.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if8r.A = 8'($urandom); if8r.B = 8'($urandom); if8r.C_in = 1'($urandom);
      tick();
      check_val("w8_hold_R",  32'(if8r.R),         32'h00);
      check_val("w8_hold_C",  32'(if8r.C_out),     32'd1);
      check_val("w8_hold_ov", 32'(if8r.out_valid), 32'd0);
    end

    // W4 reset mid-stream.
    if4r.in_valid = 1'b1;
    if4r.A = 4'h7; if4r.B = 4'h9; if4r.C_in = 1'b0;
    e5 = 5'h7 + 5'h9;
    tick();
    check_val("w4_pre", 32'({if4r.out_valid, if4r.C_out, if4r.R}), 32'({1'b1, e5}));
    rst_n = 1'b0;
    tick();
    check_val("w4_rst", 32'({if4r.out_valid, if4r.C_out, if4r.R}), 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("w4_post", 32'({if4r.out_valid, if4r.C_out, if4r.R}), 32'({1'b1, e5}));
    if4r.in_valid = 1'b0;

    // W16 random, registered and combinational side by side.
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c1  = 1'($urandom);
      v1  = ($urandom_range(0, 7) != 0);
      if (i % 97 == 0) begin
        a16 = 16'hFFFF; b16 = 16'hFFFF; c1 = 1'b1;
      end
      if16r.A = a16; if16r.B = b16; if16r.C_in = c1; if16r.in_valid = v1;
      if16c.A = a16; if16c.B = b16; if16c.C_in = c1; if16c.in_valid = v1;
      e17 = 17'(a16) + 17'(b16) + 17'(c1);
      #1;
      check_val("w16c_sum", 32'({if16c.C_out, if16c.R}), 32'(e17));
      check_val("w16c_ov",  32'(if16c.out_valid),         32'(v1));
      tick();
      if (v1)
        check_val("w16r_sum", 32'({if16r.C_out, if16r.R}), 32'(e17));
      check_val("w16r_ov", 32'(if16r.out_valid), 32'(v1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
